// File: rtl/ray_bounce_ctrl.sv
// ============================================================================
// Module  : ray_bounce_ctrl (with ray_bounce_pkg)
// Brief   : Per-ray bounce sequencer driving the intersector and reflector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ray_bounce_pkg;
    typedef logic [23:0] fp24;
    localparam fp24 FP24_ONE = 24'h3F0000;
    typedef struct packed { fp24 x; fp24 y; fp24 z; } fp24_vec3;
    typedef struct packed { fp24 r; fp24 g; fp24 b; } fp24_color;
    typedef struct packed {
        fp24_color  color;
        fp24        rough;
        logic [7:0] kind;
    } material;
endpackage

module ray_bounce_ctrl
    import ray_bounce_pkg::*;
#(
    parameter int unsigned MAX_BOUNCES = 4,
    parameter fp24_color   WHITE       = {3{FP24_ONE}}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  fp24_vec3                           in_origin,
    input  fp24_vec3                           in_dir,
    output logic                               ready,
    output logic                               isect_start,
    output fp24_vec3                           isect_origin,
    output fp24_vec3                           isect_dir,
    input  logic                               isect_done,
    input  logic                               isect_hit,
    input  fp24_vec3                           isect_pos,
    input  fp24_vec3                           isect_normal,
    input  material                            isect_mat,
    output logic                               rflx_valid,
    output fp24_vec3                           rflx_ray_dir,
    output fp24_vec3                           rflx_hit_pos,
    output fp24_vec3                           rflx_hit_normal,
    output fp24_color                          rflx_ray_color,
    output fp24_color                          rflx_income_light,
    output material                            rflx_hit_mat,
    input  logic                               rflx_done,
    input  fp24_vec3                           rflx_new_dir,
    input  fp24_vec3                           rflx_new_origin,
    input  fp24_color                          rflx_new_color,
    input  fp24_color                          rflx_new_income_light,
    output logic                               out_valid,
    output fp24_color                          out_light,
    output logic [$clog2(MAX_BOUNCES+1)-1:0]   out_bounces
);

    localparam int BW = $clog2(MAX_BOUNCES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_ISECT = 3'd2,
        S_REFLECT    = 3'd3,
        S_WAIT_RFLX  = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    fp24_vec3        r_origin;
    fp24_vec3        r_dir;
    fp24_color       r_color;
    fp24_color       r_light;
    fp24_vec3        r_pos;
    fp24_vec3        r_normal;
    material         r_mat;
    logic [BW-1:0]   r_bounce;
    fp24_color       r_out_light;
    logic [BW-1:0]   r_out_bounces;

    logic [BW-1:0]   w_bounce_inc;
    logic            w_limit;

    assign w_bounce_inc = r_bounce + BW'(1);
    assign w_limit      = (w_bounce_inc == BW'(MAX_BOUNCES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        isect_start = 1'b0;
        rflx_valid  = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                isect_start = 1'b1;
                w_state_nxt = S_WAIT_ISECT;
            end
            S_WAIT_ISECT: begin
                if (isect_done) w_state_nxt = isect_hit ? S_REFLECT : S_DONE;
            end
            S_REFLECT: begin
                rflx_valid  = 1'b1;
                w_state_nxt = S_WAIT_RFLX;
            end
            S_WAIT_RFLX: begin
                if (rflx_done) w_state_nxt = w_limit ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                out_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result registers load on the transition into DONE so they are valid with out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_origin      <= '0;
            r_dir         <= '0;
            r_color       <= '0;
            r_light       <= '0;
            r_pos         <= '0;
            r_normal      <= '0;
            r_mat         <= '0;
            r_bounce      <= '0;
            r_out_light   <= '0;
            r_out_bounces <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_origin <= in_origin;
                        r_dir    <= in_dir;
                        r_color  <= WHITE;
                        r_light  <= '0;
                        r_bounce <= '0;
                    end
                end
                S_WAIT_ISECT: begin
                    if (isect_done) begin
                        if (isect_hit) begin
                            r_pos    <= isect_pos;
                            r_normal <= isect_normal;
                            r_mat    <= isect_mat;
                        end else begin
                            r_out_light   <= r_light;
                            r_out_bounces <= r_bounce;
                        end
                    end
                end
                S_WAIT_RFLX: begin
                    if (rflx_done) begin
                        r_origin <= rflx_new_origin;
                        r_dir    <= rflx_new_dir;
                        r_color  <= rflx_new_color;
                        r_light  <= rflx_new_income_light;
                        r_bounce <= w_bounce_inc;
                        if (w_limit) begin
                            r_out_light   <= rflx_new_income_light;
                            r_out_bounces <= w_bounce_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign isect_origin      = r_origin;
    assign isect_dir         = r_dir;
    assign rflx_ray_dir      = r_dir;
    assign rflx_hit_pos      = r_pos;
    assign rflx_hit_normal   = r_normal;
    assign rflx_ray_color    = r_color;
    assign rflx_income_light = r_light;
    assign rflx_hit_mat      = r_mat;
    assign out_light         = r_out_light;
    assign out_bounces       = r_out_bounces;

endmodule

`default_nettype wire

// File: doc/ray_bounce_ctrl.md
# ray_bounce_ctrl

Per-ray bounce sequencer for the path tracer. Accepts a camera ray, alternately drives the nearest-hit intersector and the ray reflector, and carries ray colour and accumulated incoming light between bounces. Stops on a miss or after MAX_BOUNCES reflections, then emits the final incoming light for the pixel accumulator. Sits between ray generation and the pixel accumulator, directly upstream of the ray reflector (it produces the reflector's `hit_valid` and inputs) and directly downstream of it (it consumes the reflector's `new_*` outputs and `reflect_done`).

## Interface
- MAX_BOUNCES, default 4: maximum reflections per ray; must be ≥1.
- WHITE, default {3{FP24_ONE}} (fp24_color): initial ray colour.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  new camera ray request; honoured only while `ready`=1.
- in_origin / in_dir  in  fp24_vec3  camera ray, sampled in the `start` cycle.
- ready  out  1  high only in IDLE.
- isect_start  out  1  one-cycle pulse launching an intersection.
- isect_origin / isect_dir  out  fp24_vec3  current ray; stable from the `isect_start` cycle until `isect_done`.
- isect_done  in  1  intersector result pulse.
- isect_hit  in  1  valid with `isect_done`; 0 = miss.
- isect_pos / isect_normal  in  fp24_vec3; isect_mat  in  material  hit data, valid with `isect_done`.
- rflx_valid  out  1  one-cycle pulse, wired to the reflector's `hit_valid`.
- rflx_ray_dir, rflx_hit_pos, rflx_hit_normal  out  fp24_vec3; rflx_ray_color, rflx_income_light  out  fp24_color; rflx_hit_mat  out  material  all registered, stable from the `rflx_valid` cycle until `rflx_done`.
- rflx_done  in  1  the reflector's `reflect_done`.
- rflx_new_dir / rflx_new_origin  in  fp24_vec3; rflx_new_color / rflx_new_income_light  in  fp24_color  reflector results, valid with `rflx_done`.
- out_valid  out  1  one-cycle result pulse.
- out_light  out  fp24_color  final incoming light; held until the next `out_valid`.
- out_bounces  out  $clog2(MAX_BOUNCES+1)  reflections performed; held like `out_light`.

## Operation
- State machine states: IDLE, ISSUE, WAIT_ISECT, REFLECT, WAIT_RFLX, DONE.
- IDLE, on `start`:
  - latch `in_origin` / `in_dir` as the current ray;
  - color := WHITE, light := 0 (all-zero word), bounce := 0;
  - go to ISSUE.
- ISSUE: drive `isect_start`=1 for this cycle only, then go to WAIT_ISECT.
- WAIT_ISECT, on `isect_done`:
  - `isect_hit`=0 → DONE, leaving light unchanged;
  - `isect_hit`=1 → latch pos, normal and mat into the `rflx_*` registers, then go to REFLECT.
- REFLECT: drive `rflx_valid`=1 for this cycle only, then go to WAIT_RFLX.
- WAIT_RFLX, on `rflx_done`:
  - origin := new_origin, dir := new_dir, color := new_color, light := new_income_light;
  - bounce := bounce+1;
  - go to DONE if bounce+1 == MAX_BOUNCES, else go to ISSUE.
- DONE:
  - `out_valid`=1, `out_light` := light, `out_bounces` := bounce;
  - go to IDLE.
- No arithmetic inside this block. fp24 values pass through untouched. The bounce counter saturates by construction and never wraps.

## Timing
- Reset values:
  - all outputs 0, except `ready`=1;
  - state IDLE;
  - internal registers 0.
- Reset mid-operation: return to IDLE next cycle. A later `isect_done` or `rflx_done` from the aborted ray is ignored.
- `start` outside IDLE is ignored and not queued.
- `isect_done` is ignored outside WAIT_ISECT.
- `rflx_done` is ignored outside WAIT_RFLX. The reflector pulses `reflect_done` once after its own reset, so this rule is mandatory.
- Dwell times:
  - start sampled at cycle 0 → `isect_start` high in cycle 1;
  - `isect_done` at cycle t → `rflx_valid` at t+1 (hit) or `out_valid` at t+1 (miss);
  - `rflx_done` at cycle u → `isect_start` at u+1 (continue) or `out_valid` at u+1 (limit reached).
- First miss with intersector latency L gives `out_valid` at cycle L+2.
- `ready` returns to 1 in the cycle after `out_valid`. Back-to-back rays are possible with one idle cycle between them.
- `isect_done` and `rflx_done` arriving in the same cycle: only the one matching the current state is acted on.

## Test plan
- **Miss on first bounce:** reset; start with dir (0,0,1); `isect_done` with `isect_hit`=0 at cycle 5. Required: `out_valid` at cycle 6, `out_light`=0, `out_bounces`=0, `rflx_valid` never asserted.
- **Single hit then miss:**
  - Stimulus: hit mat color (0.5,0.5,0.5); reflector model returns new_color 0.5 and new_income_light (1,0,0); second intersection misses.
  - Required: exactly one `rflx_valid`, `rflx_ray_color`=WHITE, `out_light`=(1,0,0), `out_bounces`=1.
- **Bounce limit:** MAX_BOUNCES=4 with every intersection hitting. Required: exactly 4 `isect_start` pulses, 4 `rflx_valid` pulses, `out_bounces`=4, and `out_light` equal to the 4th new_income_light.
- **Spurious/unsolicited done pulses:**
  - Stimulus: pulse `rflx_done` 3 cycles after reset while in IDLE; pulse `isect_done` during WAIT_RFLX.
  - Required: no state change and no output effect from either pulse.
- **Busy start and reset abort:**
  - Stimulus: assert `start` with new rays during WAIT_ISECT; then assert `rst` during WAIT_RFLX.
  - Required: the busy `start` is ignored. The reset gives IDLE with `ready`=1 and all other outputs 0. A subsequent stale `rflx_done` produces nothing. A new `start` afterwards completes normally.
- **Stable handshake outputs:** stall `isect_done` for 50 cycles. Required: `isect_origin` and `isect_dir` stay unchanged for the whole stall, and `isect_start` pulses once.
